// File: rtl/clock_time_loader_pkg.sv
// -----------------------------------------------------------------------------
// clock_time_loader_pkg
// Shared types and constants for the digital-clock time loader:
//   - loadState_t : entry FSM states (RUN plus one WAIT state per MM:SS digit)
//   - *_MAX       : largest legal value for each entered digit
//   - POS_*       : cur_pos encodings reported to the display/UI
//   - digitLimit  : range limit of the digit expected in a given state
//   - posOf       : cur_pos value for a given state
// -----------------------------------------------------------------------------
package clock_time_loader_pkg;

    typedef enum logic [2:0] {
        RUN     = 3'd0,
        WAIT_MT = 3'd1,
        WAIT_MO = 3'd2,
        WAIT_ST = 3'd3,
        WAIT_SO = 3'd4
    } loadState_t;

    localparam logic [3:0] MT_MAX = 4'd5;
    localparam logic [3:0] MO_MAX = 4'd9;
    localparam logic [3:0] ST_MAX = 4'd5;
    localparam logic [3:0] SO_MAX = 4'd9;

    localparam logic [1:0] POS_MT  = 2'd3;
    localparam logic [1:0] POS_MO  = 2'd2;
    localparam logic [1:0] POS_ST  = 2'd1;
    localparam logic [1:0] POS_SO  = 2'd0;
    localparam logic [1:0] POS_RUN = 2'd0;

    function automatic logic [3:0] digitLimit(input loadState_t s);
        logic [3:0] lim;
        case (s)
            WAIT_MT: lim = MT_MAX;
            WAIT_MO: lim = MO_MAX;
            WAIT_ST: lim = ST_MAX;
            WAIT_SO: lim = SO_MAX;
            default: lim = 4'd0;
        endcase
        return lim;
    endfunction

    function automatic logic [1:0] posOf(input loadState_t s);
        logic [1:0] pos;
        case (s)
            WAIT_MT: pos = POS_MT;
            WAIT_MO: pos = POS_MO;
            WAIT_ST: pos = POS_ST;
            WAIT_SO: pos = POS_SO;
            default: pos = POS_RUN;
        endcase
        return pos;
    endfunction

endpackage

// File: rtl/clock_time_loader_timeout.sv
// -----------------------------------------------------------------------------
// load_timeout
// Saturating count of one-second ticks seen while load mode is active.
// `expired` is combinational and flags the tick that would bring the count to
// TIMEOUT_SECS, so the owner can abort on the very edge that samples it.
// TIMEOUT_SECS = 0 disables expiry entirely.
//   clk, rst : clock, synchronous active-high reset
//   clear    : zero the count (has priority over counting)
//   enable   : counting allowed (load mode active)
//   tick     : one-second strobe
//   expired  : this tick reaches the limit
// -----------------------------------------------------------------------------
module load_timeout #(
    parameter int TIMEOUT_SECS = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    input  logic tick,
    output logic expired
);

    localparam int CNT_W = (TIMEOUT_SECS > 0) ? $clog2(TIMEOUT_SECS + 1) : 1;
    localparam logic [CNT_W-1:0] SAT_VAL  = CNT_W'(TIMEOUT_SECS);
    localparam logic [CNT_W-1:0] LAST_VAL = (TIMEOUT_SECS > 0) ? CNT_W'(TIMEOUT_SECS - 1) : '0;
    localparam logic             TO_ON    = (TIMEOUT_SECS > 0);

    logic [CNT_W-1:0] secCount;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            secCount <= '0;
        end else if (enable && tick && (secCount != SAT_VAL)) begin
            secCount <= secCount + CNT_W'(1);
        end
    end

    assign expired = TO_ON && enable && tick && (secCount == LAST_VAL);

endmodule

// File: rtl/clock_time_loader.sv
// -----------------------------------------------------------------------------
// clock_time_loader
// Turns user key events into digit-load strobes for the clock datapath.
// Entry order is MM:SS (10's min, 1's min, 10's sec, 1's sec); each digit is
// range checked, and an accepted digit produces a one-cycle ld* strobe with
// the value on ld_num. The clock is frozen (dicRun=0) while entry is active.
// Per-cycle event priority: rst > esc_strb > set_strb > timeout > digit_strb.
//   clk, rst        : clock, synchronous active-high reset
//   set_strb        : enter / restart load mode
//   esc_strb        : abort load mode (loaded digits are kept by the datapath)
//   digit_strb      : digit is valid this cycle
//   digit[3:0]      : key value
//   i_oneSecStrb    : one-second tick used for the keyless timeout
//   ldMtens..ldSones: one-cycle load strobes (at most one high)
//   ld_num[3:0]     : loaded digit while a ld* strobe is high, else 0
//   dicRun          : 1 = clock runs
//   load_busy       : 1 while entry is in progress
//   cur_pos[1:0]    : position of the expected digit (3=Mtens .. 0=Sones)
//   dig_err         : one-cycle pulse on a rejected digit
// -----------------------------------------------------------------------------
module clock_time_loader
    import clock_time_loader_pkg::*;
#(
    parameter int TIMEOUT_SECS = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       set_strb,
    input  logic       esc_strb,
    input  logic       digit_strb,
    input  logic [3:0] digit,
    input  logic       i_oneSecStrb,
    output logic       ldMtens,
    output logic       ldMones,
    output logic       ldStens,
    output logic       ldSones,
    output logic [3:0] ld_num,
    output logic       dicRun,
    output logic       load_busy,
    output logic [1:0] cur_pos,
    output logic       dig_err
);

    loadState_t state;
    loadState_t nextState;
    logic [3:0] ldSelNext;    // {Mtens, Mones, Stens, Sones}
    logic [3:0] numNext;
    logic       digErrNext;
    logic       inWait;
    logic       timeoutHit;
    logic       toClear;

    assign inWait = (state != RUN);

    // Counter restarts whenever load mode is (re)entered or any key arrives;
    // holding it clear in RUN keeps it from counting there.
    assign toClear = !inWait || set_strb || digit_strb;

    load_timeout #(
        .TIMEOUT_SECS(TIMEOUT_SECS)
    ) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .clear  (toClear),
        .enable (inWait),
        .tick   (i_oneSecStrb),
        .expired(timeoutHit)
    );

    function automatic loadState_t advance(input loadState_t s);
        loadState_t n;
        case (s)
            WAIT_MT: n = WAIT_MO;
            WAIT_MO: n = WAIT_ST;
            WAIT_ST: n = WAIT_SO;
            default: n = RUN;
        endcase
        return n;
    endfunction

    function automatic logic [3:0] strobeFor(input loadState_t s);
        logic [3:0] sel;
        case (s)
            WAIT_MT: sel = 4'b1000;
            WAIT_MO: sel = 4'b0100;
            WAIT_ST: sel = 4'b0010;
            WAIT_SO: sel = 4'b0001;
            default: sel = 4'b0000;
        endcase
        return sel;
    endfunction

    always_comb begin
        nextState  = state;
        ldSelNext  = 4'b0000;
        numNext    = 4'd0;
        digErrNext = 1'b0;
        if (!inWait) begin
            // In RUN only set_strb matters; keys, esc and timeouts are dropped.
            if (set_strb) begin
                nextState = WAIT_MT;
            end
        end else if (esc_strb) begin
            nextState = RUN;
        end else if (set_strb) begin
            nextState = WAIT_MT;
        end else if (timeoutHit) begin
            nextState = RUN;
        end else if (digit_strb) begin
            if (digit <= digitLimit(state)) begin
                ldSelNext = strobeFor(state);
                numNext   = digit;
                nextState = advance(state);
            end else begin
                digErrNext = 1'b1;
            end
        end
    end

    // All outputs follow nextState, so the Sones strobe and dicRun rising
    // land in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RUN;
            dicRun    <= 1'b1;
            load_busy <= 1'b0;
            cur_pos   <= POS_RUN;
            ldMtens   <= 1'b0;
            ldMones   <= 1'b0;
            ldStens   <= 1'b0;
            ldSones   <= 1'b0;
            ld_num    <= 4'd0;
            dig_err   <= 1'b0;
        end else begin
            state     <= nextState;
            dicRun    <= (nextState == RUN);
            load_busy <= (nextState != RUN);
            cur_pos   <= posOf(nextState);
            ldMtens   <= ldSelNext[3];
            ldMones   <= ldSelNext[2];
            ldStens   <= ldSelNext[1];
            ldSones   <= ldSelNext[0];
            ld_num    <= numNext;
            dig_err   <= digErrNext;
        end
    end

endmodule

// File: doc/clock_time_loader.md
# clock_time_loader

Front-end loader for the digital-clock datapath: turns user key events into the datapath's digit-load strobes. Walks a fixed MM:SS entry order (10's min, 1's min, 10's sec, 1's sec), range-checks each digit, and issues a one-cycle `ldMtens`/`ldMones`/`ldStens`/`ldSones` strobe with `ld_num`. Freezes the clock (`dicRun`=0) while entry is in progress and abandons entry after a keyless timeout.

## Interface
- TIMEOUT_SECS, 10, one-second strobes without a key before load mode aborts; 0 disables the timeout
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- set_strb  in  1  one-cycle strobe: enter or restart load mode
- esc_strb  in  1  one-cycle strobe: abort load mode
- digit_strb  in  1  one-cycle strobe: `digit` valid
- digit  in  4  key value, 0-15
- i_oneSecStrb  in  1  one strobe per second
- ldMtens, ldMones, ldStens, ldSones  out  1 each  one-cycle load strobes, at most one high per cycle
- ld_num  out  4  digit value; valid when any `ld*` is high, 0 otherwise
- dicRun  out  1  1 = clock runs, 0 = frozen
- load_busy  out  1  1 while in any WAIT state
- cur_pos  out  2  expected digit: 3=Mtens, 2=Mones, 1=Stens, 0=Sones; 0 in RUN
- dig_err  out  1  one-cycle pulse on a rejected digit

## Operation
- States: RUN, WAIT_MT, WAIT_MO, WAIT_ST, WAIT_SO.
- Per-cycle event priority: rst > esc_strb > set_strb > timeout > digit_strb. Only the highest-priority event is acted on; the rest are dropped.
- RUN:
  - set_strb -> WAIT_MT.
  - digit_strb, esc_strb and timeout are ignored; no dig_err.
- Any WAIT state:
  - esc_strb -> RUN. Digits already loaded are kept.
  - set_strb -> WAIT_MT (restart).
- Digit range limits: Mtens 0-5, Mones 0-9, Stens 0-5, Sones 0-9.
- In a WAIT state, digit_strb with an in-range digit:
  - Pulses the matching ld* strobe with ld_num = digit.
  - Advances MT->MO->ST->SO->RUN.
- In a WAIT state, digit_strb with an out-of-range digit:
  - Pulses dig_err.
  - State, ld* and ld_num are unchanged.
- Timeout counter:
  - Cleared on entering any WAIT state and on every digit_strb in a WAIT state, accepted or rejected.
  - Increments on i_oneSecStrb while in a WAIT state.
  - Reaching TIMEOUT_SECS -> RUN, with no ld* pulse.
  - Saturating; width $clog2(TIMEOUT_SECS+1).
  - Never counts in RUN.
- dicRun = (state == RUN). load_busy = ~dicRun.

## Timing
- All outputs are registered.
- Reset values: state RUN, dicRun 1, load_busy 0, cur_pos 0, ld* 0, ld_num 0, dig_err 0, timeout counter 0.
- Event sampled at edge N:
  - State, dicRun, load_busy and cur_pos take their new values after edge N.
  - ld*/ld_num/dig_err are high for exactly the cycle after edge N, then return to 0.
- Last digit (Sones):
  - ldSones pulse and dicRun rising occur in the same cycle.
  - The datapath loads Sones on the same edge the clock resumes.
- set_strb in RUN: dicRun falls one cycle later. An i_oneSecStrb in that same cycle still advances the clock.
- Back-to-back digit strobes on consecutive cycles are all accepted; throughput is one digit per cycle.
- Mid-operation reset returns to RUN on the next edge; a pending ld* pulse is cancelled.
- Timeout: the abort takes effect on the edge that samples the TIMEOUT_SECS-th i_oneSecStrb.

## Structure
- Package clock_time_loader_pkg:
  - State enum (RUN, WAIT_MT, WAIT_MO, WAIT_ST, WAIT_SO).
  - Digit-limit constants: MT_MAX=5, MO_MAX=9, ST_MAX=5, SO_MAX=9.
  - cur_pos encodings.
- One sub-module, load_timeout: the parameterised saturating second counter with clear, enable and `expired` outputs.
- FSM, range check and output registers live in the top.

## Test plan
- Reset, then set_strb, then digits 1,2,3,4 on separate cycles:
  - ldMtens/ldMones/ldStens/ldSones pulse in order with ld_num 1,2,3,4.
  - dicRun is 0 from one cycle after set_strb until it rises with the ldSones pulse.
- set_strb, then digit 7:
  - dig_err pulses, no ld*, cur_pos stays 3.
  - Digit 5 is then accepted: ldMtens with ld_num 5, cur_pos becomes 2.
- set_strb, digits 2,3, then esc_strb:
  - Exactly two ld* pulses.
  - dicRun returns to 1 one cycle after esc_strb; load_busy 0.
- TIMEOUT_SECS=3: set_strb, digit 4, then three i_oneSecStrb with no keys:
  - Returns to RUN after the 3rd strobe.
  - Only ldMtens pulsed.
- set_strb, esc_strb and digit_strb in the same cycle while in WAIT_MO:
  - esc wins: RUN next cycle, no ld*, no dig_err.
- rst asserted on the cycle a valid Stens digit arrives: no ldStens pulse, state RUN, dicRun 1.
